e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit in the EX stage, beside the ALU.
//  Executes mult/multu/div/divu into internal HI/LO registers and services mthi/mtlo.
//  Reports busy so the hazard unit stalls any md instruction in D while the unit is working.
//  Widens the single-cycle ALU with sequential latency, operand latching and a start/busy handshake.
// PARAMETERS
//  WIDTH        32  operand width; HI and LO are WIDTH each
//  MULT_CYCLES  5   busy cycles after a multiply start (>=1)
//  DIV_CYCLES   10  busy cycles after a divide start (>=1)
// PORTS
//  clk      in   1      single clock, rising edge
//  reset    in   1      synchronous, active-high
//  start    in   1      1-cycle pulse: issue md_op with operands a and b
//  md_op    in   4      operation code: mult, multu, div, divu, mthi, mtlo, none
//  a        in   WIDTH  rs operand (forwarded)
//  b        in   WIDTH  rt operand (forwarded)
//  busy     out  1      operation in flight
//  hi       out  WIDTH  HI register (mfhi source)
//  lo       out  WIDTH  LO register (mflo source)
// BEHAVIOUR
//  Reset: busy=0, hi=0, lo=0, counter=0, state=IDLE. A reset while BUSY aborts the
//   operation; its result is never committed.
//  FSM IDLE -> BUSY:
//   - at the edge ending cycle T, when start=1 and md_op is mult, multu, div or divu;
//   - a and b are latched at that edge; later changes on a and b have no effect;
//   - the counter is loaded with MULT_CYCLES or DIV_CYCLES.
//  While BUSY, the counter decrements each cycle and busy=1 during cycles T+1..T+N.
//   At the edge ending T+N the FSM returns to IDLE and hi/lo take the result.
//   From cycle T+1+N: busy=0 and the new hi/lo are visible.
//  Stall contract: the hazard unit stalls any md instruction in D while (start | busy).
//   A start asserted while busy=1 is a protocol error: it is ignored, with no state change.
//  mthi/mtlo (start=1, IDLE): hi<=a or lo<=a at the edge ending T; busy stays 0.
//  Arithmetic:
//   - mult: {hi,lo} = $signed(a)*$signed(b), full 2*WIDTH-bit product;
//   - multu: the same, unsigned;
//   - div: lo = signed quotient, truncated toward zero; hi = remainder with the sign of a;
//   - divu: the same, unsigned.
//  Division boundary cases:
//   - divide by zero (b=0): the full busy sequence still runs; hi and lo are left unchanged;
//   - signed overflow (a = -2^(WIDTH-1), b = -1): lo = a, hi = 0; no exception.
//  Outputs are registered; hi and lo hold their values while busy (mfhi reads the old value,
//   but stall logic prevents that).
//  md_op = none, or start=0: no action.
// STRUCTURE
//  Operation codes (`md_none, `md_mult, `md_multu, `md_div, `md_divu, `md_mthi, `md_mtlo)
//   are defined in const.v alongside the alu_* codes.
//  The result is computed combinationally from the latched operands into pending hi/lo,
//   then committed when the counter expires.
//  Two-state FSM plus counter of width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
//  One natural sub-module: e_mdu_arith (combinational result for op/a/b, including the
//   divide-by-zero flag); everything sequential stays in e_mdu.
// TESTING
//  1 mult a=32'hFFFF_FFFE(-2) b=3, start at T -> busy=1 on T+1..T+5; at T+6
//    hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, busy=0.
//  2 multu a=32'hFFFF_FFFF b=32'hFFFF_FFFF -> after 5 busy cycles hi=32'hFFFF_FFFE,
//    lo=32'h0000_0001.
//  3 div a=-7 b=2 -> 10 busy cycles, then lo=32'hFFFF_FFFD(-3), hi=32'hFFFF_FFFF(-1);
//    divu a=7 b=2 -> lo=3, hi=1.
//  4 mthi a=32'h1234_5678, then div with b=0 -> busy for 10 cycles; afterwards
//    hi=32'h1234_5678 and lo unchanged.
//  5 div a=32'h8000_0000 b=32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
//  6 mult start, reset=1 in the 3rd busy cycle -> next cycle busy=0, hi=lo=0, and the result
//    is never committed; a second start while busy (no reset) changes neither the count nor
//    the operands.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared definitions for the EX-stage multiply/divide unit.
//   md_op_e     : operation codes carried on md_op (4 bits)
//   mdu_state_e : two-state sequencer state (idle / busy)
//   is_long_op  : true for ops that occupy the unit for several cycles
//   is_div_op   : true for div/divu (selects the longer latency)
package e_mdu_pkg;

   typedef enum logic [3:0] {
      md_none  = 4'd0,
      md_mult  = 4'd1,
      md_multu = 4'd2,
      md_div   = 4'd3,
      md_divu  = 4'd4,
      md_mthi  = 4'd5,
      md_mtlo  = 4'd6
   } md_op_e;

   typedef enum logic {
      st_idle = 1'b0,
      st_busy = 1'b1
   } mdu_state_e;

   function automatic logic is_long_op(input logic [3:0] op);
      return (op == md_mult) || (op == md_multu) ||
             (op == md_div)  || (op == md_divu);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == md_div) || (op == md_divu);
   endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// e_mdu_arith: purely combinational result generator for the md unit.
//   op       in  4      latched operation code
//   a, b     in  WIDTH  latched operands
//   res_hi   out WIDTH  value HI should take on commit
//   res_lo   out WIDTH  value LO should take on commit
//   div_zero out 1      div/divu with b == 0; HI/LO must not be written
module e_mdu_arith
   import e_mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             div_zero
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;
   logic               a_neg;
   logic               b_neg;
   logic               b_zero;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   dvs_s;
   logic [WIDTH-1:0]   dvs_u;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   q_s;
   logic [WIDTH-1:0]   r_s;
   logic [WIDTH-1:0]   q_u;
   logic [WIDTH-1:0]   r_u;

   // Operands are extended to 2*WIDTH before multiplying; the low 2*WIDTH
   // bits of the extended product are exact in two's complement.
   assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   // Signed division is done on magnitudes and the signs restored after,
   // which gives truncation toward zero and a remainder signed like a.
   // -2^(W-1) / -1 falls out naturally: the quotient magnitude 2^(W-1)
   // negates back to itself, remainder 0.
   assign a_neg  = a[WIDTH-1];
   assign b_neg  = b[WIDTH-1];
   assign b_zero = (b == '0);
   assign mag_a  = a_neg ? ('0 - a) : a;
   assign mag_b  = b_neg ? ('0 - b) : b;
   // A zero divisor is replaced by 1 so the dividers never see /0; the
   // result is discarded through div_zero anyway.
   assign dvs_s  = b_zero ? ONE : mag_b;
   assign dvs_u  = b_zero ? ONE : b;
   assign q_mag  = mag_a / dvs_s;
   assign r_mag  = mag_a % dvs_s;
   assign q_s    = (a_neg ^ b_neg) ? ('0 - q_mag) : q_mag;
   assign r_s    = a_neg ? ('0 - r_mag) : r_mag;
   assign q_u    = a / dvs_u;
   assign r_u    = a % dvs_u;

   always_comb begin
      res_hi   = '0;
      res_lo   = '0;
      div_zero = 1'b0;
      case (op)
         md_mult: begin
            res_hi = prod_s[2*WIDTH-1:WIDTH];
            res_lo = prod_s[WIDTH-1:0];
         end
         md_multu: begin
            res_hi = prod_u[2*WIDTH-1:WIDTH];
            res_lo = prod_u[WIDTH-1:0];
         end
         md_div: begin
            res_hi   = r_s;
            res_lo   = q_s;
            div_zero = b_zero;
         end
         md_divu: begin
            res_hi   = r_u;
            res_lo   = q_u;
            div_zero = b_zero;
         end
         default: begin
            res_hi   = '0;
            res_lo   = '0;
            div_zero = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit beside the ALU in EX.
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-high; aborts an operation in flight
//   start  in   1      one-cycle issue pulse for md_op with operands a/b
//   md_op  in   4      md_none/mult/multu/div/divu/mthi/mtlo
//   a      in   WIDTH  rs operand
//   b      in   WIDTH  rt operand
//   busy   out  1      operation in flight (hazard unit stalls md instrs)
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
//
// Handshake: an issue is accepted only on a cycle with start=1 while
// busy=0. A long op then holds busy=1 for exactly MULT_CYCLES or
// DIV_CYCLES cycles; HI/LO change on the edge that drops busy. A start
// seen while busy=1 is dropped without touching any state. mthi/mtlo
// write on the issue edge and never raise busy.
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       md_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   mdu_state_e       state_q;
   mdu_state_e       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic             div_zero;
   logic             issue_ok;
   logic             start_long;
   logic             done;

   // The result is formed from the latched operands only, so a/b may
   // change freely once the issue edge has passed.
   e_mdu_arith #(.WIDTH(WIDTH)) u_arith (
      .op       (op_q),
      .a        (a_q),
      .b        (b_q),
      .res_hi   (res_hi),
      .res_lo   (res_lo),
      .div_zero (div_zero)
   );

   assign issue_ok   = start && (state_q == st_idle);
   assign start_long = issue_ok && is_long_op(md_op);
   // Counter holds the number of busy cycles left including this one.
   assign done       = (state_q == st_busy) && (cnt_q == CNT_W'(1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         st_idle: if (start_long) state_d = st_busy;
         st_busy: if (done)       state_d = st_idle;
         default:                 state_d = st_idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= st_idle;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         op_q  <= md_none;
         a_q   <= '0;
         b_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         if (start_long) begin
            op_q  <= md_op;
            a_q   <= a;
            b_q   <= b;
            cnt_q <= is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         end else if (state_q == st_busy) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (done && !div_zero) begin
               hi_q <= res_hi;
               lo_q <= res_lo;
            end
         end
         if (issue_ok && (md_op == md_mthi)) hi_q <= a;
         if (issue_ok && (md_op == md_mtlo)) lo_q <= a;
      end
   end

   assign busy = (state_q == st_busy);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed bench for e_mdu. The driver issues operations and
// pushes {busy_len, hi, lo} for every long op expected to commit; the
// monitor measures each busy run and pops/compares when busy drops.
module tb_e_mdu;
   import e_mdu_pkg::*;

   localparam int W = 32;

   logic         clk;
   logic         reset;
   logic         start;
   logic [3:0]   md_op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   logic [2*W+7:0] exp_q[$];
   int             checks;
   int             errors;
   int             busy_len;
   logic           abort;

   e_mdu #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after a rising edge; outputs are sampled
   // on falling edges.
   task automatic pulse(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
      @(posedge clk); #1;
      start = 1'b1;
      md_op = op;
      a     = av;
      b     = bv;
      @(posedge clk); #1;
      start = 1'b0;
      md_op = md_none;
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic wait_idle(input string name);
      bit seen_idle;
      seen_idle = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            seen_idle = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen_idle) begin
         errors++;
         $display("FAIL %s_timeout: busy still %b after 40 cycles, required 0", name, busy);
      end
   endtask

   task automatic long_op(input string name, input logic [3:0] op,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int len, input logic [W-1:0] ehi, input logic [W-1:0] elo);
      exp_q.push_back({8'(len), ehi, elo});
      pulse(op, av, bv);
      wait_idle(name);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [2*W+7:0] item;
      if (busy === 1'b1) begin
         busy_len++;
      end else if (busy_len > 0) begin
         if (!abort) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_completion: hi %h lo %h with no expected entry", hi, lo);
            end else begin
               item = exp_q.pop_front();
               check("busy_len", W'(busy_len), W'(item[2*W+7:2*W]));
               check("hi", hi, item[2*W-1:W]);
               check("lo", lo, item[W-1:0]);
            end
         end
         busy_len = 0;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      checks   = 0;
      errors   = 0;
      busy_len = 0;
      abort    = 1'b0;
      reset    = 1'b1;
      start    = 1'b0;
      md_op    = md_none;
      a        = '0;
      b        = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_busy", W'(busy), W'(0));
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);

      // start=0 with a long op on md_op does nothing
      @(posedge clk); #1;
      md_op = md_mult; a = 32'd9; b = 32'd9;
      @(posedge clk); #1;
      md_op = md_none;
      @(negedge clk);
      check("nostart_busy", W'(busy), W'(0));

      long_op("mult_neg", md_mult, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      long_op("multu_max", md_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
      long_op("div_neg", md_div, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      long_op("divu", md_divu, 32'd7, 32'd2, 10, 32'd1, 32'd3);

      // mthi / mtlo write on the issue edge without raising busy
      pulse(md_mthi, 32'h1234_5678, 32'h0);
      @(negedge clk);
      check("mthi_busy", W'(busy), W'(0));
      check("mthi_hi", hi, 32'h1234_5678);
      check("mthi_lo", lo, 32'd3);
      pulse(md_mtlo, 32'hCAFE_BABE, 32'h0);
      @(negedge clk);
      check("mtlo_busy", W'(busy), W'(0));
      check("mtlo_hi", hi, 32'h1234_5678);
      check("mtlo_lo", lo, 32'hCAFE_BABE);

      // divide by zero: full busy run, HI/LO untouched
      long_op("div_zero", md_div, 32'd55, 32'd0, 10, 32'h1234_5678, 32'hCAFE_BABE);
      long_op("divu_zero", md_divu, 32'd55, 32'd0, 10, 32'h1234_5678, 32'hCAFE_BABE);
      // signed overflow
      long_op("div_ovf", md_div, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
      long_op("mult_mixed", md_mult, 32'd7, 32'hFFFF_FFFB, 5, 32'hFFFF_FFFF, 32'hFFFF_FFDD);
      long_op("div_pos_neg", md_div, 32'd100, 32'hFFFF_FFF9, 10, 32'd2, 32'hFFFF_FFF2);

      // a second start while busy is ignored: length and operands unchanged
      exp_q.push_back({8'd5, 32'h0, 32'd12});
      pulse(md_mult, 32'd3, 32'd4);
      pulse(md_div, 32'd100, 32'd7);
      wait_idle("restart");

      // start with md_none: no action
      pulse(md_none, 32'hDEAD_BEEF, 32'h1);
      @(negedge clk);
      check("none_busy", W'(busy), W'(0));
      check("none_hi", hi, 32'h0);
      check("none_lo", lo, 32'd12);

      // reset in the 3rd busy cycle aborts the multiply
      pulse(md_mult, 32'd5, 32'd6);    // now in cycle T+1
      @(posedge clk); #1;              // T+2
      @(posedge clk); #1;              // T+3
      abort = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;              // T+4
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", W'(busy), W'(0));
      check("abort_hi", hi, 32'h0);
      check("abort_lo", lo, 32'h0);
      repeat (6) @(negedge clk);
      check("abort_later_busy", W'(busy), W'(0));
      check("abort_later_hi", hi, 32'h0);
      check("abort_later_lo", lo, 32'h0);
      abort = 1'b0;

      // the unit works normally after the abort
      long_op("post_abort", md_multu, 32'h0001_0000, 32'h0001_0000, 5, 32'h1, 32'h0);

      repeat (3) @(negedge clk);
      check("queue_drain", W'(exp_q.size()), W'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
